dds_signal_gen: RTL
===================

DDS_SIGNAL_GEN -- requirements
Module: dds_signal_gen

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 sample_en  input  1  sample strobe; one accumulator step per high cycle; may be high every cycle.
REQ-004 phase_M  input  ROM_PHASE_BIT-1  phase increment (tuning word) from the control unit.
REQ-005 signal_A  input  DAC_MAX_V_BIT-1  amplitude, unsigned, full scale 2^(D-1)-1.
REQ-006 signal_shape  input  2  0 sine, 1 triangle, 2 square, 3 off (mid-scale).
REQ-007 dac_code  output  DAC_MAX_V_BIT  offset-binary DAC sample, registered.
REQ-008 dac_valid  output  1  one-cycle pulse per new dac_code.
REQ-009 phase_wrap  output  1  one-cycle pulse, aligned with dac_valid, for the first sample after accumulator carry-out (scope trigger).
Notation: P = ROM_PHASE_BIT, D = DAC_MAX_V_BIT, Q = ROM_ADDR_BIT; P >= D+1.

Function
REQ-010 Shadow registers for M, A and shape shall load from the inputs on a sample_en cycle when the accumulator add carries out, or when shadow M == 0; otherwise they hold.
REQ-011 Accumulator: P bits; on sample_en, s1_phase <= acc, and acc <= (acc + shadow M) mod 2^P; no change otherwise.
REQ-012 Stage 2 shall form signed waveform w in [-(2^(D-1)-1), +(2^(D-1)-1)] from s1_phase and shadow shape.
REQ-013 Sine: quadrant = phase[P-1:P-2]; LUT address = phase[P-3:P-2-Q], bit-inverted in quadrants 1 and 3; w negated in quadrants 2 and 3.
REQ-014 LUT entry k = round((2^(D-1)-1)*sin(pi/2*k/2^Q)), unsigned D-1 bits, registered read (1 cycle).
REQ-015 Triangle: r = phase[P-2:P-D-1] when phase MSB = 0, else its bitwise inverse; w = max(r - 2^(D-1), -(2^(D-1)-1)).
REQ-016 Square: w = +(2^(D-1)-1) when phase MSB = 0, else -(2^(D-1)-1).
REQ-017 Shape 3: w = 0.
REQ-018 Stage 3: dac_code = 2^(D-1) + floor(w*A / 2^(D-1)) (arithmetic shift); the result shall lie in [0, 2^D-1] and saturate there if ever outside.
REQ-019 Latency: sample_en in cycle n -> dac_valid and dac_code update in cycle n+3; throughput one sample per cycle.
REQ-020 dac_code shall hold its value between dac_valid pulses.
REQ-021 Accumulator wrap is modulo 2^P with no lost phase; a carry-out in the same cycle as a parameter change applies the new M from the next step.
REQ-022 Parameter changes not at a wrap shall not alter the current period's shape, amplitude or increment.

Reset
REQ-023 On rst: acc, s1_phase, shadow M/A/shape, pipeline valids = 0; dac_code = 2^(D-1); dac_valid = 0; phase_wrap = 0.
REQ-024 rst mid-pipeline shall discard in-flight samples; no dac_valid until 3 cycles after the first post-reset sample_en.
REQ-025 rst has priority over sample_en in the same cycle.

Structure
REQ-026 ROM_PHASE_BIT, DAC_MAX_V_BIT, ROM_ADDR_BIT and shape encodings (SHAPE_SIN=0, SHAPE_TRI=1, SHAPE_SQR=2, SHAPE_OFF=3) shall live in the shared config header.
REQ-027 The quarter-wave table shall be one sub-module, dds_sine_lut (clk, addr[Q-1:0], data[D-2:0], registered output); all other logic stays in dds_signal_gen.

Verification (P=12, D=12, Q=8)
REQ-028 Square, A=2047, M=1024, sample_en constant -> dac_code 4094,4094,1,1 repeating from cycle 3; phase_wrap on every 4th valid.
REQ-029 Sine, A=2047, M=1024 -> codes 2048,4094,2048,2 repeating (+/-1 LSB per LUT rounding).
REQ-030 Any shape, A=0, or shape=3 with A=2047 -> every dac_code = 2048.
REQ-031 Triangle running at M=16; change M to 64 and shape to square mid-period -> old waveform continues until the wrap, new settings from the first post-wrap sample.
REQ-032 rst asserted 1 cycle after sample_en, mid-pipeline -> dac_valid stays 0, dac_code = 2048 next cycle, acc = 0.
REQ-033 sample_en one cycle in four -> exactly one dac_valid per strobe, each 3 cycles after its strobe; dac_code stable in between.

Source files
------------

// File: rtl/dds_signal_gen_pkg.sv
// Shared configuration for the DDS signal generator: widths, shape encodings
// and the elaboration-time quarter-wave sine table builder.
package dds_signal_gen_pkg;

  localparam int ROM_PHASE_BIT = 12;
  localparam int DAC_MAX_V_BIT = 12;
  localparam int ROM_ADDR_BIT  = 8;

  localparam int LUT_DEPTH  = 2 ** ROM_ADDR_BIT;
  localparam int LUT_WIDTH  = DAC_MAX_V_BIT - 1;
  localparam int FULL_SCALE = 2 ** (DAC_MAX_V_BIT - 1) - 1;

  typedef enum logic [1:0] {
    SHAPE_SIN = 2'd0,
    SHAPE_TRI = 2'd1,
    SHAPE_SQR = 2'd2,
    SHAPE_OFF = 2'd3
  } shape_e;

  // Entry k sits at bits [k*LUT_WIDTH +: LUT_WIDTH]; built top entry first.
  function automatic logic [LUT_DEPTH*LUT_WIDTH-1:0] build_sine_table();
    logic [LUT_DEPTH*LUT_WIDTH-1:0] tbl;
    logic [LUT_WIDTH-1:0]           entry;
    real                            angle;
    tbl = '0;
    for (int k = LUT_DEPTH - 1; k >= 0; k--) begin
      angle = 1.5707963267948966 * real'(k) / real'(LUT_DEPTH);
      entry = LUT_WIDTH'($rtoi($sin(angle) * real'(FULL_SCALE) + 0.5));
      tbl   = {tbl[LUT_DEPTH*LUT_WIDTH-LUT_WIDTH-1:0], entry};
    end
    return tbl;
  endfunction

endpackage

// File: rtl/dds_signal_gen_sine_lut.sv
// Quarter-wave sine magnitude table with a registered read port.
module dds_sine_lut
  import dds_signal_gen_pkg::*;
(
  input  logic                    clk,
  input  logic [ROM_ADDR_BIT-1:0] addr,
  output logic [LUT_WIDTH-1:0]    data
);

  localparam logic [LUT_DEPTH*LUT_WIDTH-1:0] TABLE = build_sine_table();

  logic [LUT_WIDTH-1:0] w_rom [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_rom
    assign w_rom[k] = TABLE[k*LUT_WIDTH +: LUT_WIDTH];
  end

  // ROM read, one cycle of latency
  always_ff @(posedge clk) begin
    data <= w_rom[addr];
  end

endmodule

// File: rtl/dds_signal_gen.sv
// Direct digital synthesis generator: phase accumulator with wrap-synchronous
// parameter shadows, waveform shaping stage and amplitude scaling to offset binary.
module dds_signal_gen
  import dds_signal_gen_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_en,
  input  logic [ROM_PHASE_BIT-2:0] phase_M,
  input  logic [DAC_MAX_V_BIT-2:0] signal_A,
  input  logic [1:0]               signal_shape,
  output logic [DAC_MAX_V_BIT-1:0] dac_code,
  output logic                     dac_valid,
  output logic                     phase_wrap
);

  localparam int P = ROM_PHASE_BIT;
  localparam int D = DAC_MAX_V_BIT;
  localparam int Q = ROM_ADDR_BIT;

  localparam logic signed [D-1:0]   W_POS    = D'(FULL_SCALE);
  localparam logic signed [D-1:0]   W_NEG    = -W_POS;
  localparam logic signed [D-1:0]   W_MIN    = {1'b1, {(D-1){1'b0}}};
  localparam logic [D-1:0]          MID_CODE = D'(2 ** (D - 1));
  localparam logic signed [2*D-1:0] MID_WIDE = (2*D)'(2 ** (D - 1));

  // stage 1: accumulator, shadows and sampled phase
  logic [P-1:0] r_acc;
  logic [P-2:0] r_sh_m;
  logic [D-2:0] r_sh_a;
  shape_e       r_sh_shape;
  logic         r_carry_last;
  logic         r_s1_valid;
  logic [P-1:0] r_s1_phase;
  logic [D-2:0] r_s1_amp;
  shape_e       r_s1_shape;
  logic         r_s1_wrap;

  logic [P:0]   w_sum;
  logic         w_load;

  assign w_sum  = {1'b0, r_acc} + {2'b00, r_sh_m};
  assign w_load = w_sum[P] | (r_sh_m == '0);

  // Each sample carries the shadow settings in force when it was taken, so a
  // reload at the wrap only affects samples from the next step onwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_sh_m       <= '0;
      r_sh_a       <= '0;
      r_sh_shape   <= SHAPE_SIN;
      r_carry_last <= 1'b0;
      r_s1_valid   <= 1'b0;
      r_s1_phase   <= '0;
      r_s1_amp     <= '0;
      r_s1_shape   <= SHAPE_SIN;
      r_s1_wrap    <= 1'b0;
    end else if (sample_en) begin
      r_s1_valid   <= 1'b1;
      r_s1_phase   <= r_acc;
      r_s1_amp     <= r_sh_a;
      r_s1_shape   <= r_sh_shape;
      r_s1_wrap    <= r_carry_last;
      r_acc        <= w_sum[P-1:0];
      r_carry_last <= w_sum[P];
      if (w_load) begin
        r_sh_m     <= phase_M;
        r_sh_a     <= signal_A;
        r_sh_shape <= shape_e'(signal_shape);
      end else begin
        r_sh_m     <= r_sh_m;
        r_sh_a     <= r_sh_a;
        r_sh_shape <= r_sh_shape;
      end
    end else begin
      r_s1_valid <= 1'b0;
    end
  end

  // stage 2: waveform shaping
  logic [1:0]          w_quadrant;
  logic [Q-1:0]        w_lut_addr;
  logic [D-2:0]        w_lut_data;
  logic [D-1:0]        w_tri_field;
  logic [D-1:0]        w_tri_r;
  logic signed [D-1:0] w_tri_w;
  logic signed [D-1:0] w_shape_w;

  assign w_quadrant = r_s1_phase[P-1 -: 2];
  assign w_lut_addr = r_s1_phase[P-3 -: Q] ^ {Q{w_quadrant[0]}};

  if (P - 1 >= D) begin : g_tri_slice
    assign w_tri_field = r_s1_phase[P-2 -: D];
  end else begin : g_tri_pad
    assign w_tri_field = {r_s1_phase[P-2:0], {(D-P+1){1'b0}}};
  end

  assign w_tri_r = w_tri_field ^ {D{r_s1_phase[P-1]}};
  assign w_tri_w = $signed({~w_tri_r[D-1], w_tri_r[D-2:0]});

  dds_sine_lut u_lut (
    .clk  (clk),
    .addr (w_lut_addr),
    .data (w_lut_data)
  );

  // non-sine waveform value; sine comes out of the LUT one cycle later
  always_comb begin
    w_shape_w = '0;
    case (r_s1_shape)
      SHAPE_TRI: w_shape_w = (w_tri_w == W_MIN) ? W_NEG : w_tri_w;
      SHAPE_SQR: w_shape_w = r_s1_phase[P-1] ? W_NEG : W_POS;
      default:   w_shape_w = '0;
    endcase
  end

  logic                r_s2_valid;
  shape_e              r_s2_shape;
  logic [D-2:0]        r_s2_amp;
  logic                r_s2_neg;
  logic signed [D-1:0] r_s2_w;
  logic                r_s2_wrap;

  // stage 2 registers, aligned with the LUT read data
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_shape <= SHAPE_SIN;
      r_s2_amp   <= '0;
      r_s2_neg   <= 1'b0;
      r_s2_w     <= '0;
      r_s2_wrap  <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_shape <= r_s1_shape;
      r_s2_amp   <= r_s1_amp;
      r_s2_neg   <= w_quadrant[1];
      r_s2_w     <= w_shape_w;
      r_s2_wrap  <= r_s1_wrap & r_s1_valid;
    end
  end

  // stage 3: amplitude scaling, offset and saturation
  logic signed [D-1:0]   w_lut_s;
  logic signed [D-1:0]   w_wave;
  logic signed [2*D-1:0] w_prod;
  logic signed [2*D-1:0] w_code_full;
  logic [D-1:0]          w_code_sat;

  assign w_lut_s     = $signed({1'b0, w_lut_data});
  assign w_prod      = (2*D)'(w_wave) * (2*D)'($signed({1'b0, r_s2_amp}));
  assign w_code_full = (w_prod >>> (D - 1)) + MID_WIDE;

  // select signed waveform sample
  always_comb begin
    w_wave = '0;
    if (r_s2_shape == SHAPE_SIN) begin
      w_wave = r_s2_neg ? -w_lut_s : w_lut_s;
    end else begin
      w_wave = r_s2_w;
    end
  end

  // clamp to the DAC code range
  always_comb begin
    w_code_sat = '0;
    if (w_code_full[2*D-1]) begin
      w_code_sat = '0;
    end else if (|w_code_full[2*D-2:D]) begin
      w_code_sat = '1;
    end else begin
      w_code_sat = w_code_full[D-1:0];
    end
  end

  // output registers; dac_code holds between valid pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      dac_code   <= MID_CODE;
      dac_valid  <= 1'b0;
      phase_wrap <= 1'b0;
    end else if (r_s2_valid) begin
      dac_code   <= w_code_sat;
      dac_valid  <= 1'b1;
      phase_wrap <= r_s2_wrap;
    end else begin
      dac_code   <= dac_code;
      dac_valid  <= 1'b0;
      phase_wrap <= 1'b0;
    end
  end

endmodule
